// File: rtl/aes_ctr_ctrl_pkg.sv
// Shared definitions for the AES-CTR stream controller.
//   BLK_W        : AES block width (key, nonce and data are all one block wide)
//   DEF_LATENCY  : default core enable-to-valid_out depth minus one
//   state_t      : message sequencer states
package aes_ctr_ctrl_pkg;

    localparam int BLK_W       = 128;
    localparam int DEF_LATENCY = 11;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CORE_RST  = 3'd1,
        S_KEY_SETUP = 3'd2,
        S_KEY_LOAD  = 3'd3,
        S_WAIT_KEYS = 3'd4,
        S_STREAM    = 3'd5,
        S_DRAIN     = 3'd6,
        S_DONE      = 3'd7
    } state_t;

endpackage

// File: rtl/aes_ctr_out_fifo.sv
// Output FIFO for the AES-CTR controller. Absorbs every core result that is
// already in flight when the downstream consumer stalls.
// Ports:
//   clk, reset            : clock, synchronous active-high reset (clears pointers/count)
//   push, push_data       : write strobe and ciphertext from the core
//   pop                   : consumer ready; an entry leaves when pop && out_valid
//   out_valid, out_data   : head of the queue; out_valid is decoded from the
//                           registered count, so it rises the cycle after a push
//   count                 : current occupancy
//   overflow              : push while full with no pop in the same cycle (data dropped)
module aes_ctr_out_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 128,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count,
    output logic             overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             full;
    logic             pop_en;
    logic             push_en;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full      = (cnt == CW'(DEPTH));
    assign out_valid = (cnt != '0);
    assign out_data  = mem[rd_ptr];
    assign count     = cnt;

    // A pop frees the head slot in the same cycle, so a push into a full
    // FIFO is legal when it coincides with a pop.
    assign pop_en   = pop && out_valid;
    assign push_en  = push && (!full || pop_en);
    assign overflow = push && full && !pop_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_en) wr_ptr <= next_ptr(wr_ptr);
            if (pop_en)  rd_ptr <= next_ptr(rd_ptr);
            case ({push_en, pop_en})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage holds data only; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/aes_ctr_stream_ctrl.sv
// Message sequencer around a pipelined AES-CTR core without backpressure.
// One message per accepted cfg_start: reset the core, load the key, wait for
// round-key expansion, then stream cfg_num_blocks blocks. Blocks are issued
// only while the output FIFO can hold every result already in flight.
// Ports:
//   clk, reset                         : clock, synchronous active-high reset
//   cfg_key/cfg_nonce/cfg_num_blocks   : message setup, latched on accepted cfg_start
//   cfg_start                          : start pulse, ignored while busy
//   busy, done, err                    : status (done is a 1-cycle pulse, err sticky)
//   in_valid/in_ready/in_data          : plaintext stream
//   out_valid/out_ready/out_data       : ciphertext stream
//   core_*                             : AES-CTR core control and results
module aes_ctr_stream_ctrl
    import aes_ctr_ctrl_pkg::*;
#(
    parameter int LATENCY     = DEF_LATENCY,
    parameter int FIFO_DEPTH  = 16,
    parameter int KEY_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BLK_W-1:0] cfg_key,
    input  logic [BLK_W-1:0] cfg_nonce,
    input  logic [CNT_W-1:0] cfg_num_blocks,
    input  logic             cfg_start,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_data,
    output logic             core_reset_n,
    output logic [BLK_W-1:0] core_key,
    output logic [BLK_W-1:0] core_nonce,
    output logic             core_start_key_load,
    output logic             core_enable,
    output logic [BLK_W-1:0] core_plaintext,
    input  logic [BLK_W-1:0] core_ciphertext,
    input  logic             core_valid_out,
    input  logic             core_all_keys_valid
);

    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int TOW = $clog2(KEY_TIMEOUT + 1);
    localparam logic [FCW:0] CREDIT_LIM = (FCW + 1)'(FIFO_DEPTH);

    if (FIFO_DEPTH < 2) begin : g_depth_chk
        $error("aes_ctr_stream_ctrl: FIFO_DEPTH must be at least 2");
    end
    if (FIFO_DEPTH < LATENCY + 2) begin : g_tput_chk
        $warning("aes_ctr_stream_ctrl: FIFO_DEPTH below LATENCY+2 limits throughput");
    end

    state_t           state;
    state_t           state_nx;
    logic [BLK_W-1:0] key_q;
    logic [BLK_W-1:0] nonce_q;
    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] issued;
    logic [CNT_W-1:0] retired;
    logic [FCW-1:0]   inflight;
    logic [FCW-1:0]   fifo_count;
    logic [TOW-1:0]   to_cnt;
    logic             rst_cnt;
    logic             err_q;

    logic             start_acc;
    logic             credit_ok;
    logic             vld_acc;
    logic             pop;
    logic             fifo_overflow;
    logic             key_timeout;
    logic             core_rst_state;

    assign start_acc = (state == S_IDLE) && cfg_start;

    // Credit covers both queued results and results still inside the core,
    // since the core cannot be stalled once a block has been issued.
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight}) < CREDIT_LIM;

    // Stray core results outside a live stream are never queued.
    assign vld_acc = core_valid_out && ((state == S_STREAM) || (state == S_DRAIN));
    assign pop     = out_valid && out_ready;

    assign key_timeout = (state == S_WAIT_KEYS) && !core_all_keys_valid &&
                         (to_cnt == TOW'(KEY_TIMEOUT - 1));

    assign err            = err_q;
    assign core_key       = key_q;
    assign core_nonce     = nonce_q;
    assign core_plaintext = in_data;
    assign core_reset_n   = !(reset || core_rst_state);

    always_comb begin
        state_nx            = state;
        busy                = (state != S_IDLE);
        done                = 1'b0;
        in_ready            = 1'b0;
        core_enable         = 1'b0;
        core_start_key_load = 1'b0;
        core_rst_state      = 1'b0;
        case (state)
            S_IDLE: begin
                if (cfg_start) state_nx = (cfg_num_blocks == '0) ? S_DONE : S_CORE_RST;
            end
            S_CORE_RST: begin
                core_rst_state = 1'b1;
                if (rst_cnt) state_nx = S_KEY_SETUP;
            end
            S_KEY_SETUP: state_nx = S_KEY_LOAD;
            S_KEY_LOAD: begin
                core_start_key_load = 1'b1;
                state_nx            = S_WAIT_KEYS;
            end
            S_WAIT_KEYS: begin
                if (core_all_keys_valid) state_nx = S_STREAM;
                else if (key_timeout)    state_nx = S_DONE;
            end
            S_STREAM: begin
                in_ready    = credit_ok && (issued < num_q);
                core_enable = in_valid && in_ready;
                if (core_enable && (issued + CNT_W'(1) == num_q)) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (retired == num_q) state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            num_q    <= '0;
            issued   <= '0;
            retired  <= '0;
            inflight <= '0;
            to_cnt   <= '0;
            rst_cnt  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (start_acc) begin
                num_q    <= cfg_num_blocks;
                issued   <= '0;
                retired  <= '0;
                inflight <= '0;
                err_q    <= 1'b0;
            end else begin
                if (core_enable) issued  <= issued + CNT_W'(1);
                if (pop)         retired <= retired + CNT_W'(1);
                case ({core_enable, vld_acc})
                    2'b10:   inflight <= inflight + FCW'(1);
                    2'b01:   inflight <= inflight - FCW'(1);
                    default: inflight <= inflight;
                endcase
                if (key_timeout || fifo_overflow) err_q <= 1'b1;
            end
            // Toggles once inside CORE_RST, giving a two-cycle core reset.
            rst_cnt <= (state == S_CORE_RST) ? ~rst_cnt : 1'b0;
            to_cnt  <= (state == S_WAIT_KEYS) ? to_cnt + TOW'(1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (start_acc) begin
            key_q   <= cfg_key;
            nonce_q <= cfg_nonce;
        end
    end

    aes_ctr_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BLK_W),
        .CW    (FCW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (vld_acc),
        .push_data (core_ciphertext),
        .pop       (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .count     (fifo_count),
        .overflow  (fifo_overflow)
    );

endmodule

// File: tb/tb_aes_ctr_stream_ctrl.sv
module tb_aes_ctr_stream_ctrl;

    localparam int LAT = 11;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] cfg_key, cfg_nonce;
    logic [31:0]  cfg_num_blocks;
    logic         cfg_start;
    logic         busy, done, err;
    logic         in_valid, in_ready;
    logic [127:0] in_data;
    logic         out_valid, out_ready;
    logic [127:0] out_data;
    logic         core_reset_n;
    logic [127:0] core_key, core_nonce;
    logic         core_start_key_load, core_enable;
    logic [127:0] core_plaintext, core_ciphertext;
    logic         core_valid_out, core_all_keys_valid;

    aes_ctr_stream_ctrl dut (
        .clk(clk), .reset(reset),
        .cfg_key(cfg_key), .cfg_nonce(cfg_nonce), .cfg_num_blocks(cfg_num_blocks),
        .cfg_start(cfg_start), .busy(busy), .done(done), .err(err),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .core_reset_n(core_reset_n), .core_key(core_key), .core_nonce(core_nonce),
        .core_start_key_load(core_start_key_load), .core_enable(core_enable),
        .core_plaintext(core_plaintext), .core_ciphertext(core_ciphertext),
        .core_valid_out(core_valid_out), .core_all_keys_valid(core_all_keys_valid)
    );

    always #5 clk = ~clk;

    // Keystream of the stand-in core: any fixed function of (key, counter).
    function automatic logic [127:0] ks(input logic [127:0] k, input logic [127:0] c);
        return k ^ {c[63:0], c[127:64]} ^ (c * 128'h9E3779B97F4A7C15F39CC0605CEDC835);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Stand-in pipelined CTR core: counter reloads nonce on first enable after reset.
    logic [LAT:0] vpipe;
    logic [127:0] dpipe [0:LAT];
    logic [127:0] ctr_q;
    logic         started;
    int           kv_cnt = 0;
    bit           stub_never = 1'b0;

    assign core_valid_out      = vpipe[LAT];
    assign core_ciphertext     = dpipe[LAT];
    assign core_all_keys_valid = !stub_never && (kv_cnt >= 10);

    always @(posedge clk) begin
        if (!core_reset_n) begin
            vpipe   <= '0;
            started <= 1'b0;
            kv_cnt  <= 0;
        end else begin
            if (core_start_key_load)         kv_cnt <= 1;
            else if (kv_cnt > 0 && kv_cnt < 10) kv_cnt <= kv_cnt + 1;
            vpipe    <= {vpipe[LAT-1:0], core_enable};
            dpipe[0] <= core_plaintext ^ ks(core_key, started ? ctr_q + 128'd1 : core_nonce);
            for (int i = 1; i <= LAT; i++) dpipe[i] <= dpipe[i-1];
            if (core_enable) begin
                ctr_q   <= started ? ctr_q + 128'd1 : core_nonce;
                started <= 1'b1;
            end
        end
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference: i-th accepted block of a message must come out as data ^ ks(key, nonce+i).
    logic [127:0] m_key, m_nonce;
    logic [127:0] exp_q[$];
    logic [127:0] got_q[$];
    int acc_cnt, en_cnt, kl_cnt, crn_cnt, done_cnt;
    int first_acc_cyc, first_ov_cyc, first_en_cyc, last_en_cyc, kl_cyc, done_cyc, start_cyc;
    bit err_seen, err_at_done;
    logic s_busy, s_done, s_err, s_in_ready, s_out_valid, s_core_en, s_kl, s_crn, s_hs;
    logic [127:0] s_core_key, s_core_nonce;

    task automatic clear_mon();
        exp_q.delete(); got_q.delete();
        acc_cnt = 0; en_cnt = 0; kl_cnt = 0; crn_cnt = 0; done_cnt = 0;
        first_acc_cyc = -1; first_ov_cyc = -1; first_en_cyc = -1; last_en_cyc = -1;
        kl_cyc = -1; done_cyc = -1; err_seen = 0; err_at_done = 0;
    endtask

    task automatic sample();
        s_busy = busy; s_done = done; s_err = err; s_in_ready = in_ready;
        s_out_valid = out_valid; s_core_en = core_enable; s_kl = core_start_key_load;
        s_crn = core_reset_n; s_core_key = core_key; s_core_nonce = core_nonce;
        s_hs = in_valid && in_ready;
        if (in_valid && in_ready) begin
            exp_q.push_back(in_data ^ ks(m_key, m_nonce + 128'(acc_cnt)));
            if (acc_cnt == 0) first_acc_cyc = cyc;
            acc_cnt++;
        end
        if (out_valid && out_ready) got_q.push_back(out_data);
        if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
        if (core_enable) begin
            if (en_cnt == 0) first_en_cyc = cyc;
            last_en_cyc = cyc;
            en_cnt++;
        end
        if (core_start_key_load) begin kl_cnt++; kl_cyc = cyc; end
        if (!core_reset_n && !reset) crn_cnt++;
        if (done) begin done_cnt++; done_cyc = cyc; err_at_done = err; end
        if (err) err_seen = 1;
    endtask

    // One clock: sample at the falling edge, return just after the rising edge.
    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_msg(input logic [127:0] k, input logic [127:0] n, input int nb);
        m_key = k; m_nonce = n;
        clear_mon();
        cfg_key = k; cfg_nonce = n; cfg_num_blocks = 32'(nb);
        cfg_start = 1'b1;
        start_cyc = cyc;
        step();
        cfg_start = 1'b0;
        cfg_key = rnd128(); cfg_nonce = rnd128(); cfg_num_blocks = $urandom;
    endtask

    task automatic run_until_done(input int max_cyc, input int v_pct, input int r_pct,
                                  input bit fixed, input logic [127:0] fdata,
                                  input bit poke, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (!in_valid || s_hs) begin
                in_valid = ($urandom_range(99) < v_pct);
                in_data  = fixed ? fdata : rnd128();
            end
            out_ready = ($urandom_range(99) < r_pct);
            if (poke && i == 3) begin
                cfg_start = 1'b1; cfg_key = ~m_key; cfg_nonce = m_nonce + 128'd100;
                cfg_num_blocks = 32'd3;
            end else begin
                cfg_start = 1'b0;
            end
            step();
            if (s_done) begin ok = 1'b1; break; end
        end
        cfg_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        repeat (3) step();
        checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", s_busy); end
        checks++; if (s_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", s_done); end
        checks++; if (s_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", s_err); end
        checks++; if (s_in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", s_in_ready); end
        checks++; if (s_out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", s_out_valid); end
        checks++; if (s_core_en !== 1'b0) begin failures++; $display("FAIL rst_core_en got=%b exp=0", s_core_en); end
        checks++; if (s_kl !== 1'b0) begin failures++; $display("FAIL rst_key_load got=%b exp=0", s_kl); end
        checks++; if (s_crn !== 1'b0) begin failures++; $display("FAIL rst_core_reset_n got=%b exp=0", s_crn); end
        reset = 1'b0; in_valid = 1'b0;
        step();
        checks++; if (s_crn !== 1'b1) begin failures++; $display("FAIL idle_core_reset_n got=%b exp=1", s_crn); end
        checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", s_busy); end
    endtask

    task automatic test_basic();
        bit ok;
        start_msg(128'h0f1571c947d9e8590cb7add6af7f6798, 128'd1, 4);
        run_until_done(300, 100, 100, 1'b1, {16{8'h22}}, 1'b0, ok);
        in_valid = 1'b0;
        repeat (3) step();
        checks++; if (!ok) begin failures++; $display("FAIL basic_done_timeout got=0 exp=1"); end
        checks++; if (crn_cnt !== 2) begin failures++; $display("FAIL basic_core_rst_cycles got=%0d exp=2", crn_cnt); end
        checks++; if (kl_cnt !== 1) begin failures++; $display("FAIL basic_key_load_pulses got=%0d exp=1", kl_cnt); end
        checks++; if (en_cnt !== 4) begin failures++; $display("FAIL basic_enables got=%0d exp=4", en_cnt); end
        checks++; if (last_en_cyc - first_en_cyc !== 3) begin failures++; $display("FAIL basic_b2b_span got=%0d exp=3", last_en_cyc - first_en_cyc); end
        checks++; if (first_ov_cyc - first_acc_cyc !== 13) begin failures++; $display("FAIL basic_latency got=%0d exp=13", first_ov_cyc - first_acc_cyc); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt); end
        checks++; if (err_seen !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", err_seen); end
        checks++; if (got_q.size() !== 4) begin failures++; $display("FAIL basic_out_count got=%0d exp=4", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL basic_out[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        start_msg(rnd128(), rnd128(), 40);
        run_until_done(80, 100, 0, 1'b0, '0, 1'b0, ok);
        checks++; if (acc_cnt !== 16) begin failures++; $display("FAIL bp_accepts_stalled got=%0d exp=16", acc_cnt); end
        checks++; if (s_in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", s_in_ready); end
        checks++; if (s_out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid got=%b exp=1", s_out_valid); end
        checks++; if (err_seen !== 1'b0) begin failures++; $display("FAIL bp_err_stalled got=%b exp=0", err_seen); end
        run_until_done(600, 100, 100, 1'b0, '0, 1'b0, ok);
        in_valid = 1'b0;
        repeat (3) step();
        checks++; if (!ok) begin failures++; $display("FAIL bp_done_timeout got=0 exp=1"); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL bp_done_pulses got=%0d exp=1", done_cnt); end
        checks++; if (err_seen !== 1'b0) begin failures++; $display("FAIL bp_err got=%b exp=0", err_seen); end
        checks++; if (got_q.size() !== 40) begin failures++; $display("FAIL bp_out_count got=%0d exp=40", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_out[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_zero_len();
        in_valid = 1'b1; in_data = rnd128(); out_ready = 1'b1;
        start_msg(rnd128(), rnd128(), 0);
        step();
        checks++; if (s_done !== 1'b1) begin failures++; $display("FAIL zl_done got=%b exp=1", s_done); end
        checks++; if (s_busy !== 1'b1) begin failures++; $display("FAIL zl_busy_in_done got=%b exp=1", s_busy); end
        step();
        checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL zl_busy_after got=%b exp=0", s_busy); end
        repeat (10) step();
        in_valid = 1'b0;
        checks++; if (done_cyc - start_cyc !== 1) begin failures++; $display("FAIL zl_done_delay got=%0d exp=1", done_cyc - start_cyc); end
        checks++; if (kl_cnt !== 0) begin failures++; $display("FAIL zl_key_load got=%0d exp=0", kl_cnt); end
        checks++; if (en_cnt !== 0) begin failures++; $display("FAIL zl_enables got=%0d exp=0", en_cnt); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL zl_done_pulses got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_key_timeout();
        bit ok;
        stub_never = 1'b1;
        start_msg(rnd128(), rnd128(), 3);
        run_until_done(200, 100, 100, 1'b0, '0, 1'b0, ok);
        in_valid = 1'b0;
        repeat (2) step();
        checks++; if (!ok) begin failures++; $display("FAIL kt_done_timeout got=0 exp=1"); end
        checks++; if (done_cyc - kl_cyc !== 65) begin failures++; $display("FAIL kt_timeout_cycles got=%0d exp=65", done_cyc - kl_cyc); end
        checks++; if (err_at_done !== 1'b1) begin failures++; $display("FAIL kt_err_at_done got=%b exp=1", err_at_done); end
        checks++; if (en_cnt !== 0) begin failures++; $display("FAIL kt_enables got=%0d exp=0", en_cnt); end
        checks++; if (s_err !== 1'b1) begin failures++; $display("FAIL kt_err_sticky got=%b exp=1", s_err); end
        checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL kt_busy got=%b exp=0", s_busy); end
        stub_never = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n;
        in_valid = 1'b0; out_ready = 1'b1;
        start_msg(rnd128(), rnd128(), 10);
        step();
        checks++; if (s_err !== 1'b0) begin failures++; $display("FAIL rm_err_cleared got=%b exp=0", s_err); end
        n = 0;
        while (!s_in_ready && n < 100) begin step(); n++; end
        checks++; if (!s_in_ready) begin failures++; $display("FAIL rm_stream_timeout got=0 exp=1"); end
        in_valid = 1'b1;
        repeat (5) begin in_data = rnd128(); step(); end
        in_valid = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        checks++; if (acc_cnt !== 5) begin failures++; $display("FAIL rm_accepts got=%0d exp=5", acc_cnt); end
        checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL rm_busy got=%b exp=0", s_busy); end
        checks++; if (s_out_valid !== 1'b0) begin failures++; $display("FAIL rm_out_valid got=%b exp=0", s_out_valid); end
        clear_mon();
        repeat (20) step();
        checks++; if (first_ov_cyc !== -1) begin failures++; $display("FAIL rm_stale_output got=%0d exp=-1", first_ov_cyc); end
        start_msg(rnd128(), rnd128(), 2);
        run_until_done(300, 100, 100, 1'b0, '0, 1'b0, ok);
        in_valid = 1'b0;
        repeat (3) step();
        checks++; if (!ok) begin failures++; $display("FAIL rm_done_timeout got=0 exp=1"); end
        checks++; if (got_q.size() !== 2) begin failures++; $display("FAIL rm_out_count got=%0d exp=2", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rm_out[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_robustness();
        bit ok;
        start_msg(rnd128(), rnd128(), 6);
        run_until_done(1000, 50, 60, 1'b0, '0, 1'b1, ok);
        in_valid = 1'b0;
        repeat (5) step();
        checks++; if (!ok) begin failures++; $display("FAIL rb_done_timeout got=0 exp=1"); end
        checks++; if (s_core_key !== m_key) begin failures++; $display("FAIL rb_key_latched got=%h exp=%h", s_core_key, m_key); end
        checks++; if (s_core_nonce !== m_nonce) begin failures++; $display("FAIL rb_nonce_latched got=%h exp=%h", s_core_nonce, m_nonce); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL rb_done_pulses got=%0d exp=1", done_cnt); end
        checks++; if (en_cnt !== 6) begin failures++; $display("FAIL rb_enables got=%0d exp=6", en_cnt); end
        checks++; if (got_q.size() !== 6) begin failures++; $display("FAIL rb_out_count got=%0d exp=6", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rb_out[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        reset = 1'b1; cfg_start = 1'b0; cfg_key = '0; cfg_nonce = '0; cfg_num_blocks = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        s_hs = 1'b0;
        m_key = '0; m_nonce = '0;
        clear_mon();
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_len();
        test_key_timeout();
        test_reset_mid();
        test_robustness();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
